dc_motor_hbridge_pwm: RTL and testbench

Wishbone-mapped PWM and direction driver for the DC motor PMOD: it replaces the single on/off pin with a duty-cycled enable (`o_pwm`) and a direction line (`o_dir`) for the H-bridge. Sits on the same Wishbone peripheral bus as the other PMOD peripherals, directly upstream of the PMOD H-bridge pins. It adds:
- soft-start/soft-stop duty ramping;
- a mandatory brake-to-zero and dead-time sequence on every direction reversal.

---
 rtl/dc_motor_pkg.sv | 30 +++
 rtl/dc_motor_pwm_core.sv | 39 +++
 rtl/dc_motor_hbridge_pwm.sv | 154 +++++++++++++++
 tb/tb_dc_motor_hbridge_pwm.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_motor_pkg.sv
// Shared types and register map for the DC motor H-bridge PWM driver.
package dc_motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2,
    ST_DEAD  = 2'd3
  } state_t;

  localparam logic [3:0] REG_CTRL   = 4'd0;
  localparam logic [3:0] REG_PERIOD = 4'd1;
  localparam logic [3:0] REG_DUTY   = 4'd2;
  localparam logic [3:0] REG_STEP   = 4'd3;
  localparam logic [3:0] REG_STATUS = 4'd4;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_DIR = 1;

  function automatic logic [31:0] wb_merge(input logic [31:0] old,
                                           input logic [31:0] wdat,
                                           input logic [3:0]  sel);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/dc_motor_pwm_core.sv
// PWM counter with period shadow register and registered compare output.
module dc_motor_pwm_core #(
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 999
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_hold,
  input  logic             i_pwm_en,
  input  logic [CNT_W-1:0] i_period,
  input  logic [CNT_W-1:0] i_duty,
  output logic             o_pwm,
  output logic             o_boundary
);

  logic [CNT_W-1:0] cnt_q, per_act_q;

  // Held counter never wraps, so no boundary (and no shadow load) while idle.
  assign o_boundary = ~i_hold & (cnt_q == per_act_q);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      per_act_q <= CNT_W'(DEF_PERIOD);
      o_pwm     <= 1'b0;
    end else begin
      o_pwm <= i_pwm_en & (cnt_q < i_duty);
      if (i_hold) begin
        cnt_q <= '0;
      end else if (o_boundary) begin
        cnt_q     <= '0;
        per_act_q <= i_period;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dc_motor_hbridge_pwm.sv
// Wishbone-mapped PWM/direction driver: registers, soft ramp, and the
// brake -> dead-time -> reverse sequencing FSM for the H-bridge PMOD.
module dc_motor_hbridge_pwm
  import dc_motor_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int DEF_PERIOD = 999,
  parameter int DEAD_CYC   = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [5:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_pwm,
  output logic        o_dir
);

  localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  state_t           state_q, state_nxt;
  logic             en_q, dir_req_q, dir_act_q;
  logic [CNT_W-1:0] period_q, duty_q, step_q, cur_duty_q, cur_duty_nxt;
  logic [CNT_W-1:0] goal, ramp;
  logic [CNT_W:0]   up_sum, dn_gap;
  logic [DEAD_W-1:0] dead_q;
  logic             wb_req, boundary, hold, pwm_en;
  logic [31:0]      rd_data, ctrl_old, ctrl_w, per_w, duty_w, step_w;
  logic             unused_bits;

  assign wb_req = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign o_dir  = dir_act_q;

  always_comb begin
    ctrl_old = '0;
    ctrl_old[CTRL_EN]  = en_q;
    ctrl_old[CTRL_DIR] = dir_req_q;
  end

  assign ctrl_w = wb_merge(ctrl_old, i_wb_dat, i_wb_sel);
  assign per_w  = wb_merge({{(32-CNT_W){1'b0}}, period_q}, i_wb_dat, i_wb_sel);
  assign duty_w = wb_merge({{(32-CNT_W){1'b0}}, duty_q},   i_wb_dat, i_wb_sel);
  assign step_w = wb_merge({{(32-CNT_W){1'b0}}, step_q},   i_wb_dat, i_wb_sel);
  assign unused_bits = ^{i_wb_adr[1:0], ctrl_w[31:2], per_w[31:CNT_W],
                         duty_w[31:CNT_W], step_w[31:CNT_W]};

  always_comb begin
    rd_data = '0;
    case (i_wb_adr[5:2])
      REG_CTRL:   rd_data = ctrl_old;
      REG_PERIOD: rd_data[CNT_W-1:0] = period_q;
      REG_DUTY:   rd_data[CNT_W-1:0] = duty_q;
      REG_STEP:   rd_data[CNT_W-1:0] = step_q;
      REG_STATUS: begin
        rd_data[0]            = (state_q == ST_RUN);
        rd_data[1]            = dir_act_q;
        rd_data[3:2]          = state_q;
        rd_data[16 +: CNT_W]  = cur_duty_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:  if (en_q) state_nxt = ST_RUN;
      ST_RUN:   if (!en_q || (dir_req_q != dir_act_q)) state_nxt = ST_BRAKE;
      ST_BRAKE: if (cur_duty_q == '0) state_nxt = ST_DEAD;
      ST_DEAD:  if (dead_q == '0) state_nxt = en_q ? ST_RUN : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Sums/differences carry an extra bit so a large STEP saturates at the goal.
  always_comb begin
    goal   = (state_q == ST_RUN) ? duty_q : '0;
    up_sum = {1'b0, cur_duty_q} + {1'b0, step_q};
    dn_gap = {1'b0, cur_duty_q} - {1'b0, goal};
    if (step_q == '0)
      ramp = goal;
    else if (cur_duty_q < goal)
      ramp = (up_sum >= {1'b0, goal}) ? goal : up_sum[CNT_W-1:0];
    else
      ramp = (dn_gap <= {1'b0, step_q}) ? goal : cur_duty_q - step_q;
    cur_duty_nxt = cur_duty_q;
    if (state_q == ST_IDLE)
      cur_duty_nxt = '0;
    else if (boundary && (state_q == ST_RUN || state_q == ST_BRAKE))
      cur_duty_nxt = ramp;
  end

  // Counter also clears on the DEAD->IDLE edge so a re-enable starts at 0.
  assign hold   = (state_q == ST_IDLE) || (state_nxt == ST_IDLE);
  assign pwm_en = (state_q == ST_RUN) || (state_q == ST_BRAKE);

  dc_motor_pwm_core #(.CNT_W(CNT_W), .DEF_PERIOD(DEF_PERIOD)) u_core (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_hold     (hold),
    .i_pwm_en   (pwm_en),
    .i_period   (period_q),
    .i_duty     (cur_duty_q),
    .o_pwm      (o_pwm),
    .o_boundary (boundary)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      en_q       <= 1'b0;
      dir_req_q  <= 1'b0;
      dir_act_q  <= 1'b0;
      period_q   <= CNT_W'(DEF_PERIOD);
      duty_q     <= '0;
      step_q     <= '0;
      cur_duty_q <= '0;
      dead_q     <= '0;
      o_wb_ack   <= 1'b0;
      o_wb_dat   <= '0;
    end else begin
      state_q    <= state_nxt;
      cur_duty_q <= cur_duty_nxt;
      if (state_q == ST_BRAKE && state_nxt == ST_DEAD)
        dead_q <= DEAD_W'(DEAD_CYC - 1);
      else if (state_q == ST_DEAD && dead_q != '0)
        dead_q <= dead_q - DEAD_W'(1);
      if (state_nxt == ST_RUN && state_q != ST_RUN)
        dir_act_q <= dir_req_q;
      o_wb_ack <= wb_req;
      if (wb_req) begin
        o_wb_dat <= rd_data;
        if (i_wb_we) begin
          case (i_wb_adr[5:2])
            REG_CTRL: begin
              en_q      <= ctrl_w[CTRL_EN];
              dir_req_q <= ctrl_w[CTRL_DIR];
            end
            REG_PERIOD: period_q <= per_w[CNT_W-1:0];
            REG_DUTY:   duty_q   <= duty_w[CNT_W-1:0];
            REG_STEP:   step_q   <= step_w[CNT_W-1:0];
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_dc_motor_hbridge_pwm.sv
// Bench for dc_motor_hbridge_pwm: directed scenarios plus random register
// traffic, all outputs compared every cycle with a behavioural model.
module tb_dc_motor_hbridge_pwm;

  localparam int DEF_PERIOD = 999;
  localparam int DEAD_CYC   = 1000;
  localparam int S_IDLE = 0, S_RUN = 1, S_BRAKE = 2, S_DEAD = 3;

  logic        clk = 1'b0, rst = 1'b1;
  logic [5:0]  adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [31:0] rdat;
  logic        ack, pwm, dir;

  always #5 clk = ~clk;

  dc_motor_hbridge_pwm #(.CNT_W(16), .DEF_PERIOD(DEF_PERIOD), .DEAD_CYC(DEAD_CYC)) dut (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_dat(rdat),
    .o_wb_ack(ack), .o_pwm(pwm), .o_dir(dir)
  );

  int n_chk = 0, n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_state, m_cnt, m_per, m_cur, m_dead, m_period, m_duty, m_step, m_nbnd;
  bit m_en, m_dreq, m_dir, m_pwm, m_ack;
  logic [31:0] m_dat;

  function automatic int toward(input int a, input int g, input int s);
    if (s == 0) return g;
    if (a < g)  return (a + s >= g) ? g : a + s;
    return (a - s <= g) ? g : a - s;
  endfunction

  function automatic int fsm_next();
    case (m_state)
      S_IDLE:  return m_en ? S_RUN : S_IDLE;
      S_RUN:   return (!m_en || m_dreq != m_dir) ? S_BRAKE : S_RUN;
      S_BRAKE: return (m_cur == 0) ? S_DEAD : S_BRAKE;
      default: return (m_dead > 0) ? S_DEAD : (m_en ? S_RUN : S_IDLE);
    endcase
  endfunction

  function automatic bit m_hold();
    return (m_state == S_IDLE) || (fsm_next() == S_IDLE);
  endfunction

  function automatic bit m_wrap();
    return !m_hold() && (m_cnt == m_per);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input logic [3:0] idx);
    case (idx)
      4'd0: return {30'b0, m_dreq, m_en};
      4'd1: return 32'(m_period);
      4'd2: return 32'(m_duty);
      4'd3: return 32'(m_step);
      4'd4: return (32'(m_cur) << 16) | (32'(m_state) << 2) | (32'(m_dir) << 1)
                   | 32'(m_state == S_RUN);
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state <= S_IDLE; m_cnt <= 0; m_per <= DEF_PERIOD; m_cur <= 0; m_dead <= 0;
      m_period <= DEF_PERIOD; m_duty <= 0; m_step <= 0;
      m_en <= 0; m_dreq <= 0; m_dir <= 0; m_pwm <= 0; m_ack <= 0; m_dat <= '0;
    end else begin
      m_state <= fsm_next();
      m_pwm   <= (m_state == S_RUN || m_state == S_BRAKE) && (m_cnt < m_cur);
      m_cnt   <= (m_hold() || m_wrap()) ? 0 : m_cnt + 1;
      if (m_wrap()) begin
        m_per  <= m_period;
        m_nbnd <= m_nbnd + 1;
      end
      if (m_state == S_IDLE) m_cur <= 0;
      else if (m_wrap() && m_state == S_RUN)   m_cur <= toward(m_cur, m_duty, m_step);
      else if (m_wrap() && m_state == S_BRAKE) m_cur <= toward(m_cur, 0, m_step);
      if (m_state == S_BRAKE && fsm_next() == S_DEAD) m_dead <= DEAD_CYC - 1;
      else if (m_state == S_DEAD && m_dead > 0)      m_dead <= m_dead - 1;
      if (fsm_next() == S_RUN && m_state != S_RUN) m_dir <= m_dreq;
      m_ack <= cyc && stb && !m_ack;
      if (cyc && stb && !m_ack) begin
        m_dat <= mread(adr[5:2]);
        if (we) begin
          case (adr[5:2])
            4'd0: {m_dreq, m_en} <= 2'(merge({30'b0, m_dreq, m_en}, wdat, sel));
            4'd1: m_period <= int'(merge(32'(m_period), wdat, sel) & 32'hFFFF);
            4'd2: m_duty   <= int'(merge(32'(m_duty),   wdat, sel) & 32'hFFFF);
            4'd3: m_step   <= int'(merge(32'(m_step),   wdat, sel) & 32'hFFFF);
            default: ;
          endcase
        end
      end
    end
  end

  initial m_nbnd = 0;

  // every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("pwm", 32'(pwm), 32'(m_pwm));
      chk("dir", 32'(dir), 32'(m_dir));
      chk("ack", 32'(ack), 32'(m_ack));
      if (m_ack) chk("rdata", rdat, m_dat);
      if (n_err >= 50) begin
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
      end
    end
  end

  time rises[$];
  logic pwm_prev = 1'b0;
  always @(negedge clk) begin
    if (pwm && !pwm_prev) rises.push_back($time);
    pwm_prev <= pwm;
  end

  // ---------------- bus and timing helpers ----------------
  task automatic wb(input int idx, input bit w, input logic [31:0] d, input logic [3:0] s,
                    output logic [31:0] r);
    @(negedge clk);
    adr = 6'(idx << 2); wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) break;
    end
    if (!ack) chk("wb_ack_timeout", 32'(ack), 32'd1);
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    logic [31:0] dmy;
    wb(idx, 1'b1, d, 4'hF, dmy);
  endtask

  task automatic rd(input int idx, output logic [31:0] r);
    wb(idx, 1'b0, 32'h0, 4'hF, r);
  endtask

  task automatic wait_bnd(input int n);
    for (int k = 0; k < n; k++) begin
      int n0, i;
      n0 = m_nbnd;
      for (i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (m_nbnd != n0) break;
      end
      if (i == 3000) chk("boundary_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #3000000;
    chk("global_timeout", 32'd0, 32'd1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    int hi, cyc_n, k, op;
    int exp_ramp[5] = '{2, 4, 6, 8, 8};

    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    rst = 1'b0;

    // reset values
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    for (int i = 0; i < 6; i++) begin
      rd(i, r);
      chk($sformatf("rst_reg%0d", i), r, (i == 1) ? 32'd999 : 32'd0);
    end

    // byte lanes and read-only STATUS
    wb(2, 1'b1, 32'hABCD, 4'b0001, r);
    rd(2, r); chk("byte_sel", r, 32'h0000_00CD);
    wr(4, 32'hFFFF_FFFF);
    rd(4, r); chk("status_ro", r, 32'h0);

    // fixed duty 3/10
    do_reset();
    wr(1, 9); wr(2, 3); wr(3, 0); wr(0, 1);
    wait_bnd(2);
    hi = 0;
    repeat (10) begin @(negedge clk); hi += int'(pwm); end
    chk("duty3_high", 32'(hi), 32'd3);
    rd(4, r);
    chk("run_bit", 32'(r[0]), 32'd1);
    chk("dir_fwd0", 32'(dir), 32'd0);

    // ramp up with STEP=2
    do_reset();
    wr(1, 9); wr(3, 2); wr(2, 8); wr(0, 1);
    for (int i = 0; i < 5; i++) begin
      wait_bnd(1);
      rd(4, r);
      chk($sformatf("ramp%0d", i), 32'(r[31:16]), 32'(exp_ramp[i]));
    end

    // direction reversal from duty 6
    wr(3, 0); wr(2, 6);
    wait_bnd(1);
    rd(4, r); chk("flip_start", 32'(r[31:16]), 32'd6);
    wr(3, 3); wr(0, 3);
    @(negedge clk);
    wait_bnd(1);
    rd(4, r);
    chk("brake_duty3", 32'(r[31:16]), 32'd3);
    chk("brake_state", 32'(r[3:2]), 32'd2);
    wait_bnd(1);
    hi = 0; cyc_n = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      cyc_n++;
      hi += int'(pwm);
      if (dir) break;
    end
    chk("dead_cycles", 32'(cyc_n), 32'(DEAD_CYC + 1));
    chk("dead_pwm_high", 32'(hi), 32'd0);
    chk("flip_dir", 32'(dir), 32'd1);
    wait_bnd(1);
    rd(4, r);
    chk("restart_ramp", 32'(r[31:16]), 32'd3);
    chk("status_dir", 32'(r[1]), 32'd1);

    // PERIOD write mid-period
    wr(3, 0); wr(2, 1);
    wait_bnd(2);
    rises.delete();
    for (k = 0; k < 50 && rises.size() < 1; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    wr(1, 4);
    for (k = 0; k < 100 && rises.size() < 3; k++) @(negedge clk);
    if (rises.size() >= 3) begin
      chk("period_kept", 32'((rises[1] - rises[0]) / 10), 32'd10);
      chk("period_new",  32'((rises[2] - rises[1]) / 10), 32'd5);
    end else begin
      chk("period_pulses", 32'(rises.size()), 32'd3);
    end

    // duty above period -> constant high
    wr(2, 15);
    wait_bnd(2);
    hi = 0;
    repeat (20) begin @(negedge clk); hi += int'(pwm); end
    chk("const_high", 32'(hi), 32'd20);

    // reset while running
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_pwm", 32'(pwm), 32'd0);
    @(negedge clk); rst = 1'b0;
    rd(4, r);
    chk("rst_mid_state", 32'(r[3:2]), 32'd0);
    chk("rst_mid_dir", 32'(dir), 32'd0);
    wr(1, 7);

    // random register traffic against the model
    for (int t = 0; t < 200; t++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      op = int'($urandom_range(0, 15));
      if (op < 2)        wr(0, 32'($urandom_range(0, 3)));
      else if (op < 5)   wr(1, 32'($urandom_range(2, 12)));
      else if (op < 8)   wb(2, 1'b1, $urandom, 4'($urandom_range(0, 15)), r);
      else if (op < 10)  wb(3, 1'b1, 32'($urandom_range(0, 6)), 4'($urandom_range(0, 15)), r);
      else if (op < 15)  rd(int'($urandom_range(0, 15)), r);
      else if ($urandom_range(0, 3) == 0) begin
        do_reset();
        wr(1, 32'($urandom_range(2, 12)));
      end else rd(4, r);
    end
    repeat (50) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
